// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit.
// Also imported by the control decoder.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply-divide unit.
// One shift-add or restoring-subtract step per cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e state, state_nx;

  op_e              op_q;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic [CW-1:0]    cnt;

  op_e              op_in;
  logic             sgn;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic             last;

  assign op_in  = op_e'(op);
  assign sgn    = op_is_signed(op_in);
  assign rs_neg = sgn & rs_val[WIDTH-1];
  assign rt_neg = sgn & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (cancel)    state_nx = S_IDLE;
        else if (last) state_nx = S_FINISH;
      end
      S_FINISH: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // {acc,q} is one shift register: product for
  // multiply, remainder/quotient for divide.
  logic [WIDTH:0] msum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;
  logic           fits;

  assign msum = {1'b0, acc} + {1'b0, (q[0] ? b : '0)};
  assign shl  = {acc, q[WIDTH-1]};
  assign diff = shl - {1'b0, b};
  assign fits = ~diff[WIDTH];

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               divz;

  assign prod     = {acc, q};
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
  assign quot_fix = (a_neg ^ b_neg) ? -q : q;
  assign rem_fix  = a_neg ? -acc : acc;
  assign divz     = (b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_MULT;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      acc   <= '0;
      q     <= '0;
      b     <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_in;
            a_neg <= rs_neg;
            b_neg <= rt_neg;
            acc   <= '0;
            q     <= rs_mag;
            b     <= rt_mag;
            cnt   <= '0;
          end else begin
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        S_RUN: begin
          if (!cancel) begin
            cnt <= cnt + 1'b1;
            if (op_is_div(op_q)) begin
              acc <= fits ? diff[WIDTH-1:0]
                          : shl[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], fits};
            end else begin
              acc <= msum[WIDTH:1];
              q   <= {msum[0], q[WIDTH-1:1]};
            end
          end
        end
        S_FINISH: begin
          if (!cancel) begin
            done <= 1'b1;
            if (op_is_div(op_q)) begin
              // x/0 leaves the dividend magnitude in acc
              hi <= rem_fix;
              lo <= divz ? '1 : quot_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit
// against a cycle-count behavioural model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         cancel = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference result {hi,lo} from plain arithmetic
  function automatic logic [63:0] ref_result(
      logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0)
          r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = {32'h0, a};
        else begin
          qq = sa / sb;
          rr = sa % sb;
          r = {rr[31:0], qq[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Model: countdown of remaining busy cycles
  int           rem_cyc;
  logic [W-1:0] m_hi, m_lo;
  logic         m_done;
  logic [63:0]  pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_cyc <= 0;
      m_hi <= '0;
      m_lo <= '0;
      m_done <= 1'b0;
      pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (rem_cyc > 0) begin
        if (cancel) rem_cyc <= 0;
        else if (rem_cyc == 1) begin
          {m_hi, m_lo} <= pend;
          m_done <= 1'b1;
          rem_cyc <= 0;
        end else rem_cyc <= rem_cyc - 1;
      end else if (start) begin
        rem_cyc <= W + 1;
        pend <= ref_result(op, rs_val, rt_val);
      end else begin
        if (mthi) m_hi <= rs_val;
        if (mtlo) m_lo <= rs_val;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, rem_cyc > 0);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic wait_done(string name, output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, " seen"}, done, 1'b1);
  endtask

  // Caller is at a negedge; start is applied now
  task automatic run_op(string name, logic [1:0] o,
      logic [W-1:0] a, logic [W-1:0] b,
      logic [W-1:0] eh, logic [W-1:0] el);
    int n, bc;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk({name, " lat"}, n, 33);
    chk({name, " bcnt"}, bc, 33);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] s [6];
    s = '{32'h0, 32'h1, 32'hFFFF_FFFF,
          32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
    if ($urandom % 3 == 0) return s[$urandom % 6];
    if ($urandom % 2 == 0) return W'($urandom % 1000);
    return $urandom;
  endfunction

  initial begin
    int n;
    int dc;
    #1 rst = 1'b1;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op("multu7x6", 2'b01, 32'd7, 32'd6, 32'h0, 32'd42);
    run_op("mult-3x5", 2'b00, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div-7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD);
    run_op("divu100/0", 2'b11, 32'd100, 32'd0,
           32'd100, 32'hFFFF_FFFF);
    run_op("div-5/0", 2'b10, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divmin/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000);
    run_op("divu max/10", 2'b11, 32'hFFFF_FFFF, 32'd10,
           32'd5, 32'h1999_9999);
    run_op("multu max2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h1);

    // move-to HI/LO
    mthi = 1'b1; rs_val = 32'h1111;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; rs_val = 32'h2222;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mthi", hi, 32'h1111);
    chk("mtlo", lo, 32'h2222);
    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h3333;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth hi", hi, 32'h3333);
    chk("mtboth lo", lo, 32'h3333);

    // mthi with start is ignored
    op = 2'b01; rs_val = 32'hDEAD; rt_val = 32'd0;
    start = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("mthi+start hi", hi, 32'h3333);
    chk("mthi+start busy", busy, 1'b1);
    wait_done("mthi+start", n);

    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hAAAA;
    @(negedge clk);
    mtlo = 1'b0; rs_val = 32'hBBBB;
    mthi = 1'b0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;

    // cancel mid-run
    op = 2'b01; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", busy, 1'b0);
    chk("cancel hi", hi, 32'hAAAA);
    chk("cancel lo", lo, 32'hBBBB);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("cancel nodone", dc, 0);

    // start while busy ignored
    op = 2'b01; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; rs_val = 32'd9; rt_val = 32'd9; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done("busystart", n);
    chk("busystart lo", lo, 32'd12);
    chk("busystart hi", hi, 32'd0);

    // cancel in FINISH outranks completion
    op = 2'b01; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fin busy", busy, 1'b1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("fin cancel done", done, 1'b0);
    chk("fin cancel busy", busy, 1'b0);
    chk("fin cancel lo", lo, 32'd12);

    // cancel in IDLE does not block start
    op = 2'b01; rs_val = 32'd5; rt_val = 32'd5;
    start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle cancel busy", busy, 1'b1);
    wait_done("idlecancel", n);
    chk("idlecancel lo", lo, 32'd25);

    // async reset mid-op
    op = 2'b01; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    chk("midrst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op("postrst", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom % 4 == 0);
      cancel = ($urandom % 40 == 0);
      mthi   = ($urandom % 8 == 0);
      mtlo   = ($urandom % 8 == 0);
      op     = 2'($urandom);
      rs_val = rnd_val();
      rt_val = rnd_val();
      @(negedge clk);
    end
    start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The module SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The module SHALL have port rs_val, input, WIDTH bits: multiplicand or dividend, from RegFile ReadData1.
REQ-007 The module SHALL have port rt_val, input, WIDTH bits: multiplier or divisor, from RegFile ReadData2.
REQ-008 The module SHALL have port cancel, input, 1 bit: abort the in-flight operation.
REQ-009 The module SHALL have port mthi, input, 1 bit: write rs_val into HI.
REQ-010 The module SHALL have port mtlo, input, 1 bit: write rs_val into LO.
REQ-011 The module SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse when HI and LO are updated.
REQ-013 The module SHALL have port hi, output, WIDTH bits: HI register (mfhi source).
REQ-014 The module SHALL have port lo, output, WIDTH bits: LO register (mflo source).

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FINISH.
REQ-016 In IDLE, start=1 SHALL latch op, operand magnitudes and sign flags at the edge, clear the iteration counter, and enter RUN.
REQ-017 In RUN, one shift-add or restoring-subtract iteration SHALL occur per edge; after exactly WIDTH iterations the FSM SHALL enter FINISH.
REQ-018 In FINISH, at the next edge HI/LO SHALL load the sign-corrected result, done SHALL be 1 for that following cycle only, and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge E0 gives done high in the cycle after edge E0+WIDTH+1, with HI/LO valid in that same cycle.
REQ-020 busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 A new start SHALL be accepted in the same cycle done=1.
REQ-023 MULT/MULTU SHALL produce the 2*WIDTH-bit product, with HI the upper half and LO the lower half.
REQ-024 MULT SHALL treat both operands as two's complement.
REQ-025 DIV/DIVU SHALL place the quotient in LO and the remainder in HI.
REQ-026 For DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-027 On divide by zero, LO SHALL be all ones and HI SHALL be the dividend, for both DIV and DIVU.
REQ-028 On DIV of the most negative value by -1, LO SHALL be the most negative value and HI SHALL be 0.
REQ-029 cancel=1 while busy SHALL force IDLE at the next edge, leave HI/LO unchanged and produce no done; cancel outranks completion in FINISH.
REQ-030 cancel=1 in IDLE SHALL have no effect and SHALL NOT block a simultaneous start.
REQ-031 mthi/mtlo SHALL write HI/LO at the edge only when in IDLE and start=0; otherwise they SHALL be ignored.
REQ-032 mthi and mtlo asserted together SHALL write rs_val into both HI and LO.
REQ-033 hi/lo SHALL be driven directly from registers with no combinational path from inputs.

Reset
REQ-034 When rst=1, the FSM SHALL go to IDLE immediately, without waiting for clk.
REQ-035 When rst=1, hi, lo, the counter and all datapath registers SHALL clear to 0, and busy and done SHALL clear to 0.
REQ-036 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-037 start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-038 Op encodings and the FSM state enumeration SHALL reside in shared package mdu_pkg, for use by the control decoder.
REQ-039 The unit SHALL be a single module; no sub-module is required, since the shared shift register serves both multiply and divide.

Verification
REQ-040 MULTU 7 x 6: start at E0 -> done at E0+33, HI=0, LO=42, busy high for 33 cycles.
REQ-041 MULT -3 x 5 -> HI=FFFFFFFF, LO=FFFFFFF1.
REQ-042 DIV -7 / 2 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1).
REQ-043 DIVU 100 / 0 -> LO=FFFFFFFF, HI=100.
REQ-044 DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
REQ-045 MULTU with cancel at cycle 10 -> no done, HI/LO keep their prior mthi/mtlo values, busy drops next edge; start during busy ignored; rst mid-op -> hi=lo=0 immediately.
